// File: rtl/mem_bus_pkg.sv
// gb_mem_pkg: shared constants, state/region enums and address helpers for the
// mem_bus memory-map decoder and its OAM DMA engine.
package gb_mem_pkg;

  localparam logic [15:0] EXT_LIMIT      = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE      = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT     = 16'hFDFF;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam logic [15:0] OAM_LIMIT      = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_BASE  = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_LIMIT = 16'hFEFF;
  localparam logic [15:0] HRAM_BASE      = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT     = 16'hFFFE;
  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] ECHO_OFFSET    = 16'h2000;

  localparam int         DMA_LEN      = 160;
  localparam int         HRAM_SIZE    = 127;
  localparam logic [7:0] DMA_LAST_IDX = 8'(DMA_LEN - 1);
  // DMA source pages at or above this one have nothing behind them; they copy 0xFF.
  localparam logic [7:0] DMA_NO_SRC   = 8'hFE;

  typedef enum logic [1:0] {
    IDLE,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

  typedef enum logic [2:0] {
    REG_EXT,
    REG_ECHO,
    REG_OAM,
    REG_UNUSABLE,
    REG_DMA,
    REG_HRAM
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr);
    region_e r;
    r = REG_EXT;
    if (addr <= EXT_LIMIT)                                r = REG_EXT;
    else if (addr >= ECHO_BASE && addr <= ECHO_LIMIT)     r = REG_ECHO;
    else if (addr >= OAM_BASE && addr <= OAM_LIMIT)       r = REG_OAM;
    else if (addr >= UNUSABLE_BASE && addr <= UNUSABLE_LIMIT) r = REG_UNUSABLE;
    else if (addr == DMA_REG_ADDR)                        r = REG_DMA;
    else if (addr >= HRAM_BASE && addr <= HRAM_LIMIT)     r = REG_HRAM;
    return r;
  endfunction

  // Echo RAM mirrors 0xC000-0xDDFF; the external bus only ever sees the mirror target.
  function automatic logic [15:0] echo_remap(input logic [15:0] addr);
    logic [15:0] a;
    a = addr;
    if (addr >= ECHO_BASE && addr <= ECHO_LIMIT) a = addr - ECHO_OFFSET;
    return a;
  endfunction

endpackage

// File: rtl/mem_bus_hram.sv
// hram: 127x8 high RAM. Synchronous write, asynchronous read, no reset.
// Ports: clk, we (write enable), addr (0..126), wdata, rdata (combinational).
module hram
  import gb_mem_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [HRAM_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Index 127 is not backed by storage; the decoder never selects it for HRAM.
  assign rdata = (int'(addr) < HRAM_SIZE) ? mem[addr] : 8'hFF;

endmodule

// File: rtl/mem_bus.sv
// mem_bus: CPU memory-map decoder plus 160-byte OAM DMA engine.
// Ports:
//   clk, reset (async, active-low)
//   cpu_addr/cpu_data_write/cpu_do_write in, cpu_data_read out (combinational)
//   ext_addr/ext_data_write/ext_do_write out, ext_data_read in (external bus)
//   oam_addr/oam_data_write/oam_do_write out, oam_data_read in (OAM port)
//   dma_active out (registered), dbg_state out (current DMA FSM state)
// The CPU port has no handshake: the CPU holds the address for the whole access,
// read data is valid combinationally and one write lands per rising edge while
// cpu_do_write is high.
module mem_bus
  import gb_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_write,
  input  logic        cpu_do_write,
  output logic [7:0]  cpu_data_read,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_data_write,
  output logic        ext_do_write,
  input  logic [7:0]  ext_data_read,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_write,
  output logic        oam_do_write,
  input  logic [7:0]  oam_data_read,
  output logic        dma_active,
  output logic [1:0]  dbg_state
);

  dma_state_e state;
  logic [7:0] dma_src;   // also the readable FF46 register
  logic [7:0] dma_idx;
  logic [7:0] dma_byte;

  region_e    region;
  logic       cpu_we;
  logic       dma_reg_we;
  logic       hram_we;
  logic [7:0] hram_rdata;

  assign region     = decode_region(cpu_addr);
  // Gating with reset keeps every write strobe low while the block is held in reset.
  assign cpu_we     = cpu_do_write & reset;
  assign dma_reg_we = cpu_we && (region == REG_DMA);
  assign hram_we    = cpu_we && (region == REG_HRAM);
  assign dbg_state  = state;

  hram u_hram (
    .clk   (clk),
    .we    (hram_we),
    .addr  (7'(cpu_addr - HRAM_BASE)),
    .wdata (cpu_data_write),
    .rdata (hram_rdata)
  );

  // FF46 writes win over everything, so a write mid-copy restarts at index 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dma_src    <= 8'h00;
      dma_idx    <= 8'h00;
      dma_byte   <= 8'h00;
      dma_active <= 1'b0;
    end else if (dma_reg_we) begin
      state      <= DMA_READ;
      dma_src    <= cpu_data_write;
      dma_idx    <= 8'h00;
      dma_active <= 1'b1;
    end else begin
      case (state)
        DMA_READ: begin
          dma_byte <= (dma_src >= DMA_NO_SRC) ? 8'hFF : ext_data_read;
          state    <= DMA_WRITE;
        end
        DMA_WRITE: begin
          if (dma_idx == DMA_LAST_IDX) begin
            state      <= IDLE;
            dma_active <= 1'b0;
          end else begin
            dma_idx <= dma_idx + 8'd1;
            state   <= DMA_READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ext_addr       = echo_remap(cpu_addr);
    ext_data_write = cpu_data_write;
    ext_do_write   = 1'b0;
    oam_addr       = cpu_addr[7:0];
    oam_data_write = cpu_data_write;
    oam_do_write   = 1'b0;
    if (dma_active) begin
      // DMA owns both ports; CPU writes outside HRAM/FF46 are dropped.
      ext_addr       = echo_remap({dma_src, dma_idx});
      oam_addr       = dma_idx;
      oam_data_write = dma_byte;
      oam_do_write   = (state == DMA_WRITE);
    end else begin
      ext_do_write = cpu_we && (region == REG_EXT || region == REG_ECHO);
      oam_do_write = cpu_we && (region == REG_OAM);
    end
  end

  always_comb begin
    cpu_data_read = 8'hFF;
    case (region)
      REG_HRAM:     cpu_data_read = hram_rdata;
      REG_DMA:      cpu_data_read = dma_src;
      REG_UNUSABLE: cpu_data_read = 8'hFF;
      REG_OAM:      cpu_data_read = dma_active ? 8'hFF : oam_data_read;
      default:      cpu_data_read = dma_active ? 8'hFF : ext_data_read;
    endcase
  end

endmodule
